// File: rtl/all_circuit_pkg.sv
// Shared types and constants for the dual-slope conversion sequencer.
package all_circuit_pkg;

    localparam int CNT_W         = 12;
    localparam int AZ_TICKS_DEF  = 4;
    localparam int INT_TICKS_DEF = 4;
    localparam int DEINT_MAX_DEF = 8;

    typedef enum logic [1:0] {
        AZ    = 2'd0,
        INT   = 2'd1,
        DEINT = 2'd2,
        EOC   = 2'd3
    } state_e;

    typedef logic [CNT_W-1:0] count_t;

    // One finished conversion: de-integrate tick count and over-range flag.
    typedef struct packed {
        logic   over;
        count_t count;
    } conv_t;

    function automatic count_t last_tick(input int ticks);
        return count_t'(ticks - 1);
    endfunction

endpackage

// File: rtl/all_circuit_if.sv
// Analog-side signal bundle of the converter: comparator, tick/hold controls and phase outputs.
interface all_circuit_if;

    logic L3;
    logic g2;
    logic DH;
    logic P1;
    logic P1B;
    logic S2;
    logic G4;
    logic E4;
    logic D4;

    modport master (
        output L3, g2, DH,
        input  P1, P1B, S2, G4, E4, D4
    );

    modport slave (
        input  L3, g2, DH,
        output P1, P1B, S2, G4, E4, D4
    );

endinterface

// File: rtl/all_circuit_tick_counter.sv
// Phase tick counter: advances on enabled ticks, clears on phase change, flags the last tick.
module all_circuit_tick_counter
    import all_circuit_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   clr,
    input  count_t term,
    output count_t count,
    output logic   at_term
);

    count_t count_q;

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + count_t'(1);
        end
    end

    assign count   = count_q;
    // Terminal only counts on an enabled tick, so g2=0 can never end a phase here.
    assign at_term = en && (count_q == term);

endmodule

// File: rtl/all_circuit.sv
// Dual-slope ADC sequencer: auto-zero, integrate, de-integrate, end-of-conversion.
module all_circuit
    import all_circuit_pkg::*;
#(
    parameter int AZ_TICKS  = AZ_TICKS_DEF,
    parameter int INT_TICKS = INT_TICKS_DEF,
    parameter int DEINT_MAX = DEINT_MAX_DEF
) (
    input  logic CP0,
    input  logic R_clock,
    input  logic L3,
    input  logic g2,
    input  logic DH,
    output logic P1,
    output logic P1B,
    output logic S2,
    output logic G4,
    output logic E4,
    output logic D4
);

    state_e state_q, state_d;
    conv_t  conv_q,  conv_d;
    conv_t  disp_q,  disp_d;
    count_t count;
    count_t term;
    logic   at_term;
    logic   phase_change;

    assign term = (state_q == AZ)  ? last_tick(AZ_TICKS)  :
                  (state_q == INT) ? last_tick(INT_TICKS) :
                                     last_tick(DEINT_MAX);

    assign phase_change = (state_d != state_q);

    all_circuit_tick_counter u_tick_counter (
        .clk     (CP0),
        .rst     (R_clock),
        .en      (g2),
        .clr     (phase_change),
        .term    (term),
        .count   (count),
        .at_term (at_term)
    );

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        conv_d  = conv_q;
        disp_d  = disp_q;
        unique case (state_q)
            AZ: begin
                if (at_term) state_d = INT;
            end
            INT: begin
                if (at_term) state_d = DEINT;
            end
            DEINT: begin
                // A comparator crossing beats the over-range limit on the same edge.
                if (!L3) begin
                    state_d = EOC;
                    conv_d  = '{over: 1'b0, count: count};
                end else if (at_term) begin
                    state_d = EOC;
                    conv_d  = '{over: 1'b1, count: count};
                end
            end
            EOC: begin
                state_d = AZ;
                if (DH) disp_d = conv_q;
            end
        endcase
    end

    always_ff @(posedge CP0) begin
        if (R_clock) begin
            state_q <= AZ;
            conv_q  <= '0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            conv_q  <= conv_d;
            disp_q  <= disp_d;
        end
    end

    assign P1  = (state_q == AZ);
    assign P1B = ~P1;
    assign S2  = (state_q == INT);
    assign G4  = (state_q == DEINT);
    assign E4  = (state_q == EOC);
    assign D4  = disp_q.over;

endmodule

// File: tb/tb_all_circuit.sv
// Directed scenarios plus randomized conversions checked through an expected-result scoreboard.
module tb_all_circuit;

    localparam int T_AZ  = 4;
    localparam int T_INT = 4;
    localparam int T_MAX = 8;

    logic CP0     = 1'b0;
    logic R_clock = 1'b1;

    all_circuit_if bus ();

    always #5 CP0 = ~CP0;

    all_circuit #(
        .AZ_TICKS  (T_AZ),
        .INT_TICKS (T_INT),
        .DEINT_MAX (T_MAX)
    ) dut (
        .CP0     (CP0),
        .R_clock (R_clock),
        .L3      (bus.L3),
        .g2      (bus.g2),
        .DH      (bus.DH),
        .P1      (bus.P1),
        .P1B     (bus.P1B),
        .S2      (bus.S2),
        .G4      (bus.G4),
        .E4      (bus.E4),
        .D4      (bus.D4)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int over;
        int cnt;
        int d4;
        int res;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   mon_en   = 1'b0;
    bit   post_chk = 1'b0;
    int   az_t     = 0;
    int   int_t    = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge CP0);
    endtask

    // Monitor: per-cycle phase sanity, and a scoreboard pop at every end-of-conversion.
    always @(negedge CP0) begin
        if (mon_en) begin
            if (post_chk) begin
                check("d4_after_eoc", int'(bus.D4), cur.d4);
                check("result_after_eoc", int'(dut.disp_q.count), cur.res);
                post_chk = 1'b0;
            end
            check("p1b_complement", int'(bus.P1B), int'(!bus.P1));
            check("phase_one_hot", int'(bus.P1) + int'(bus.S2) + int'(bus.G4) + int'(bus.E4), 1);
            if (bus.P1 && bus.g2) az_t++;
            if (bus.S2 && bus.g2) int_t++;
            if (bus.E4) begin
                check("sb_nonempty", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    cur = sb.pop_front();
                    check("capt_count", int'(dut.conv_q.count), cur.cnt);
                    check("capt_over", int'(dut.conv_q.over), cur.over);
                    check("az_ticks", az_t, T_AZ);
                    check("int_ticks", int_t, T_INT);
                    post_chk = 1'b1;
                end
                az_t  = 0;
                int_t = 0;
            end
        end
    end

    // Comparator level is random outside DEINT to show it is ignored there.
    task automatic wait_g4();
        int n = 0;
        while (!bus.G4 && n < 100) begin
            bus.L3 = 1'($urandom);
            step();
            n++;
        end
        check("g4_reached", int'(bus.G4), 1);
    endtask

    // One conversion with g2 held 1; crossing at count c, or over-range when c >= T_MAX.
    task automatic do_conv(input int c, input bit dh, input string tag);
        bus.DH = dh;
        bus.g2 = 1'b1;
        wait_g4();
        if (c >= T_MAX) begin
            repeat (T_MAX) begin
                bus.L3 = 1'b1;
                step();
            end
        end else begin
            repeat (c) begin
                bus.L3 = 1'b1;
                step();
            end
            bus.L3 = 1'b0;
            step();
        end
        check({tag, "_e4"}, int'(bus.E4), 1);
        bus.L3 = 1'b1;
        step();
        check({tag, "_back_to_az"}, int'(bus.P1), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int np1, ns2, ng4, ne4, n;
        bit tg;
        int c, cnt, over, d4_m, res_m, dticks, cyc;
        bit dh, prev_g4, done;

        bus.L3 = 1'b1;
        bus.g2 = 1'b0;
        bus.DH = 1'b1;
        repeat (2) step();

        check("rst_p1", int'(bus.P1), 1);
        check("rst_p1b", int'(bus.P1B), 0);
        check("rst_s2", int'(bus.S2), 0);
        check("rst_g4", int'(bus.G4), 0);
        check("rst_e4", int'(bus.E4), 0);
        check("rst_d4", int'(bus.D4), 0);
        check("rst_count", int'(dut.count), 0);

        // Full over-range conversion with phase run lengths measured in cycles.
        R_clock = 1'b0;
        bus.g2  = 1'b1;
        bus.L3  = 1'b1;
        bus.DH  = 1'b1;
        np1 = 0; ns2 = 0; ng4 = 0; ne4 = 0; n = 0;
        while (n < 60 && !(ne4 > 0 && bus.P1)) begin
            if (bus.P1) np1++;
            if (bus.S2) ns2++;
            if (bus.G4) ng4++;
            if (bus.E4) ne4++;
            step();
            n++;
        end
        check("len_az", np1, T_AZ);
        check("len_int", ns2, T_INT);
        check("len_deint", ng4, T_MAX);
        check("len_eoc", ne4, 1);
        check("ovr_d4", int'(bus.D4), 1);
        check("ovr_p1", int'(bus.P1), 1);
        check("ovr_result", int'(dut.disp_q.count), T_MAX - 1);

        // Held display: crossing at 2 with DH=0 leaves D4 and the result alone.
        do_conv(2, 1'b0, "hold");
        check("hold_capt", int'(dut.conv_q.count), 2);
        check("hold_d4", int'(bus.D4), 1);
        check("hold_result", int'(dut.disp_q.count), T_MAX - 1);

        do_conv(3, 1'b1, "cross3");
        check("cross3_d4", int'(bus.D4), 0);
        check("cross3_result", int'(dut.disp_q.count), 3);

        do_conv(T_MAX + 1, 1'b1, "ovr2");
        check("ovr2_d4", int'(bus.D4), 1);
        check("ovr2_result", int'(dut.disp_q.count), T_MAX - 1);

        // Crossing on the same edge as the over-range limit.
        do_conv(T_MAX - 1, 1'b1, "tie");
        check("tie_d4", int'(bus.D4), 0);
        check("tie_result", int'(dut.disp_q.count), T_MAX - 1);

        do_conv(0, 1'b1, "first");
        check("first_d4", int'(bus.D4), 0);
        check("first_result", int'(dut.disp_q.count), 0);

        // g2 toggling stretches auto-zero to twice its tick count.
        n  = 0;
        tg = 1'b0;
        while (bus.P1 && n < 30) begin
            n++;
            bus.g2 = tg;
            tg = ~tg;
            step();
        end
        check("toggle_az_len", n, 2 * T_AZ);
        bus.g2 = 1'b0;
        repeat (20) begin
            bus.L3 = 1'($urandom);
            step();
        end
        check("stall_s2", int'(bus.S2), 1);
        check("stall_count", int'(dut.count), 0);
        bus.g2 = 1'b1;
        bus.L3 = 1'b1;
        bus.DH = 1'b1;
        n = 0;
        while (!bus.E4 && n < 100) begin
            step();
            n++;
        end
        check("stall_e4", int'(bus.E4), 1);
        step();
        check("stall_ovr_d4", int'(bus.D4), 1);

        // Reset mid de-integrate.
        wait_g4();
        bus.L3 = 1'b1;
        repeat (3) step();
        R_clock = 1'b1;
        step();
        check("midrst_p1", int'(bus.P1), 1);
        check("midrst_p1b", int'(bus.P1B), 0);
        check("midrst_g4", int'(bus.G4), 0);
        check("midrst_d4", int'(bus.D4), 0);
        check("midrst_count", int'(dut.count), 0);
        check("midrst_result", int'(dut.disp_q.count), 0);

        // Randomized conversions: inputs driven just after each rising edge.
        @(posedge CP0);
        #1;
        R_clock = 1'b0;
        mon_en  = 1'b1;
        d4_m    = 0;
        res_m   = 0;
        for (int k = 0; k < 40; k++) begin
            c    = int'($urandom_range(0, T_MAX + 1));
            dh   = ($urandom % 4) != 0;
            over = (c >= T_MAX) ? 1 : 0;
            cnt  = over ? T_MAX - 1 : c;
            if (dh) begin
                d4_m  = over;
                res_m = cnt;
            end
            sb.push_back('{over: over, cnt: cnt, d4: d4_m, res: res_m});
            bus.DH  = dh;
            dticks  = 0;
            prev_g4 = 1'b0;
            done    = 1'b0;
            cyc     = 0;
            while (!done && cyc < 500) begin
                if (bus.G4) begin
                    if (!prev_g4) dticks = 0;
                    else          dticks += int'(bus.g2);
                end
                if (bus.E4) done = 1'b1;
                prev_g4 = bus.G4;
                bus.L3  = bus.G4 ? (dticks < c) : 1'($urandom);
                bus.g2  = ($urandom % 4) != 0;
                @(posedge CP0);
                #1;
                cyc++;
            end
            check("conv_done", int'(done), 1);
        end
        repeat (3) step();
        check("sb_drained", int'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/all_circuit.md
ALL_CIRCUIT -- requirements
Module: all_circuit

Interface
REQ-001 SHALL have parameter AZ_TICKS, default 4: auto-zero phase length in enabled ticks.
REQ-002 SHALL have parameter INT_TICKS, default 4: signal-integrate phase length in enabled ticks.
REQ-003 SHALL have parameter DEINT_MAX, default 8: maximum de-integrate ticks before over-range.
REQ-004 SHALL have port CP0, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port R_clock, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port L3, input, 1: comparator; 1 = integrator not yet crossed zero, 0 = crossed.
REQ-007 SHALL have port g2, input, 1: tick enable sampled on CP0; counters advance only when 1.
REQ-008 SHALL have port DH, input, 1: display-hold release; 1 = result/over-range may update at end of conversion.
REQ-009 SHALL have port P1, output, 1: auto-zero phase active.
REQ-010 SHALL have port P1B, output, 1: always the complement of P1.
REQ-011 SHALL have port S2, output, 1: signal-integrate phase active.
REQ-012 SHALL have port G4, output, 1: reference de-integrate phase active.
REQ-013 SHALL have port E4, output, 1: end-of-conversion pulse, one CP0 cycle.
REQ-014 SHALL have port D4, output, 1: registered over-range flag.

Function
REQ-015 SHALL implement a four-state sequencer: AZ -> INT -> DEINT -> EOC -> AZ.
REQ-016 SHALL decode P1/S2/G4/E4 directly from the state register (no added latency); exactly one is 1 at any time.
REQ-017 SHALL keep a 12-bit tick counter, incremented on each CP0 edge with g2=1, and cleared on every state change.
REQ-018 AZ: SHALL move to INT on the edge where g2=1 and counter = AZ_TICKS-1.
REQ-019 INT: SHALL move to DEINT on the edge where g2=1 and counter = INT_TICKS-1; L3 is ignored in INT.
REQ-020 DEINT: SHALL move to EOC on the first edge with L3=0, independent of g2; the current counter value is captured as the conversion count, with over-range pending = 0.
REQ-021 DEINT: SHALL move to EOC with over-range pending = 1 on the edge where L3=1, g2=1 and counter = DEINT_MAX-1.
REQ-022 Simultaneous L3=0 and the DEINT_MAX condition: crossing wins; over-range pending = 0.
REQ-023 L3=0 on the first DEINT cycle: SHALL exit on that edge with count 0.
REQ-024 EOC: SHALL last exactly one cycle, then return to AZ unconditionally, regardless of g2.
REQ-025 SHALL load D4 from over-range pending, and the internal result register from the captured count, on the EOC edge only if DH=1; with DH=0 both hold their previous values.
REQ-026 With g2=0, the counter and state SHALL hold, except for the L3 exit (REQ-020) and the EOC exit (REQ-024).

Reset
REQ-027 R_clock=1 at a CP0 edge SHALL force state AZ, counter 0, result 0, D4=0, giving P1=1, P1B=0, S2=0, G4=0, E4=0; this takes priority in any state, including mid-conversion.

Structure
REQ-028 Shared package all_circuit_pkg SHALL hold the state enum (AZ, INT, DEINT, EOC), the counter width constant (12) and the parameter defaults.
REQ-029 SHALL use one sub-module, all_circuit_tick_counter (enable, synchronous clear, terminal-compare); the sequencer stays in all_circuit.

Verification
REQ-030 Reset, then g2=1, L3=1, DH=1: P1=1 for 4 cycles, S2=1 for 4, G4=1 for 8, E4=1 for 1, then D4=1 and P1=1.
REQ-031 L3 falls at the 4th DEINT edge: E4 on the next cycle, D4=0, captured count 3.
REQ-032 Over-range conversion, then a conversion with DH=0 and crossing at count 2: D4 stays 1 and the result is unchanged.
REQ-033 g2 toggling every cycle: AZ lasts 8 cycles; g2 held 0 in INT: S2 stays 1 indefinitely.
REQ-034 R_clock=1 for one edge mid-DEINT: next cycle P1=1, G4=0, D4=0, counter 0.
REQ-035 L3=0 on the same edge as counter = 7 with g2=1: D4=0, count 7.
